// File: rtl/decode24_pkg.sv
// Shared types and defaults for the 2-to-4 sequenced decoder.
package decode24_pkg;

  localparam int unsigned HOLD_DEF = 4;
  localparam int unsigned CW_DEF   = 8;
  localparam int unsigned CODE_W   = 2;
  localparam int unsigned Y_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Binary code to one-hot pattern.
  function automatic logic [Y_W-1:0] onehot4(input logic [CODE_W-1:0] code);
    onehot4 = Y_W'(1) << code;
  endfunction

endpackage

// File: rtl/decode24_seq_hold_cnt.sv
// Loadable down-counter that saturates at zero; zero flag is combinational.
module dec_hold_cnt #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          dec_i,
  output logic          zero_c
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load wins over decrement; decrement is blocked at zero so the count cannot wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule

// File: rtl/decode24_seq.sv
// Accepts a 2-bit code, drives its one-hot decode for HOLD cycles, then pulses done.
module decode24_seq
  import decode24_pkg::*;
#(
  parameter int unsigned HOLD = HOLD_DEF,
  parameter int unsigned CW   = CW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic [Y_W-1:0]    y,
  output logic              busy,
  output logic              done
);

  state_e              state_q, state_d;
  logic [Y_W-1:0]      y_q, y_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic                cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]       cnt_load_val;

  dec_hold_cnt #(.CW(CW)) u_hold_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_c     (cnt_zero)
  );

  // Next-state and next-output logic; in_ready is the only combinational output.
  always_comb begin
    state_d      = state_q;
    y_d          = y_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    code_d       = code_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
    in_ready     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = en;
        y_d      = '0;
        busy_d   = 1'b0;
        if (in_valid && en) begin
          state_d      = DRIVE;
          code_d       = in_code;
          y_d          = onehot4(in_code);
          busy_d       = 1'b1;
          cnt_load     = 1'b1;
          cnt_load_val = CW'(HOLD - 1);
        end
      end
      DRIVE: begin
        if (!en) begin
          // Abort clears the counter so no stale count survives into the next code.
          state_d  = IDLE;
          y_d      = '0;
          busy_d   = 1'b0;
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
          state_d = DONE;
          y_d     = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          y_d     = onehot4(code_q);
          busy_d  = 1'b1;
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        y_d     = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        y_d     = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      code_q  <= code_d;
    end
  end

  assign y    = y_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
